// File: rtl/readout_frame_arbiter_if.sv
// ---------------------------------------------------------------------------
// readout_frame_arbiter_if
//   Bundles the channel request/word/ack signals and the UART transmitter
//   byte port that the readout frame arbiter drives.
//
//   req_i     NumCh     per-channel request, level-sensitive
//   data_i    NumCh*32  channel c word on bits [32c+31:32c]
//   ack_o     NumCh     one-cycle pulse: channel word latched
//   tx_data_o 8         byte to the UART transmitter
//   tx_en_o   1         write strobe to the UART transmitter
//   tx_busy_i 1         UART transmitter FIFO full
//   busy_o    1         frame in progress
//
//   master: the arbiter side.  slave: the channels + UART side.
// ---------------------------------------------------------------------------
interface readout_frame_arbiter_if #(
    parameter int NumCh = 4
);
    logic [NumCh-1:0]    req_i;
    logic [NumCh*32-1:0] data_i;
    logic [NumCh-1:0]    ack_o;
    logic [7:0]          tx_data_o;
    logic                tx_en_o;
    logic                tx_busy_i;
    logic                busy_o;

    modport master (
        input  req_i,
        input  data_i,
        input  tx_busy_i,
        output ack_o,
        output tx_data_o,
        output tx_en_o,
        output busy_o
    );

    modport slave (
        output req_i,
        output data_i,
        output tx_busy_i,
        input  ack_o,
        input  tx_data_o,
        input  tx_en_o,
        input  busy_o
    );
endinterface

// File: rtl/readout_frame_arbiter.sv
// ---------------------------------------------------------------------------
// readout_frame_arbiter
//   Shares one UART transmit byte port between NumCh measurement channels.
//   A requesting channel is picked round-robin, its 32-bit word is latched,
//   and a 7-byte frame is pushed into the UART byte FIFO:
//     A5, {5'b0,id}, w[31:24], w[23:16], w[15:8], w[7:0], xor(B1..B5)
//
//   clk   system clock (shared with the UART transmitter)
//   rstn  asynchronous active-low reset
//   bus   master modport of readout_frame_arbiter_if:
//           req_i/data_i/ack_o        channel side
//           tx_data_o/tx_en_o/tx_busy_i  UART byte FIFO side
//           busy_o                    high while a frame is being sent
// ---------------------------------------------------------------------------
module readout_frame_arbiter #(
    parameter int NumCh = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    readout_frame_arbiter_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [2:0]       last;
    logic [NumCh-1:0] ack_q;
    logic             busy_q;

    // Frame payload: no reset needed, it is only observed while in SEND.
    logic [2:0]       id_q;
    logic [31:0]      word_q;

    // Requests and words padded to the 8-channel maximum so the 3-bit
    // channel id can index them directly for any legal NumCh.
    logic [7:0]       req_pad;
    logic [255:0]     data_pad;

    logic             grant_vld;
    logic [2:0]       grant_id;
    logic [2:0]       cand;
    logic [NumCh-1:0] grant_oh;

    logic             accept;
    logic [7:0]       b1;
    logic [7:0]       chk;
    logic [7:0]       byte_sel;

    assign req_pad  = 8'(bus.req_i);
    assign data_pad = 256'(bus.data_i);

    // Round-robin search starting just above the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 3'd0;
        cand      = 3'd0;
        for (int i = 1; i <= NumCh; i++) begin
            cand = 3'((int'(last) + i) % NumCh);
            if (!grant_vld && req_pad[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int c = 0; c < NumCh; c++) begin
            grant_oh[c] = grant_vld && (grant_id == 3'(c));
        end
    end

    // A byte is taken by the UART FIFO whenever we strobe; the strobe is
    // dropped combinationally in any cycle the FIFO reports full.
    assign accept = (state == SEND) && !bus.tx_busy_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            idx    <= 3'd0;
            last   <= 3'(NumCh - 1);
            ack_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state  <= SEND;
                        last   <= grant_id;
                        idx    <= 3'd0;
                        ack_q  <= grant_oh;
                        busy_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (idx == 3'd6) begin
                            state  <= IDLE;
                            idx    <= 3'd0;
                            busy_q <= 1'b0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word and id are captured on the grant edge only, so later changes on
    // data_i cannot disturb the frame in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_vld) begin
            word_q <= data_pad[{grant_id, 5'b0} +: 32];
            id_q   <= grant_id;
        end
    end

    assign b1  = {5'b0, id_q};
    assign chk = b1 ^ word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];

    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            3'd0:    byte_sel = 8'hA5;
            3'd1:    byte_sel = b1;
            3'd2:    byte_sel = word_q[31:24];
            3'd3:    byte_sel = word_q[23:16];
            3'd4:    byte_sel = word_q[15:8];
            3'd5:    byte_sel = word_q[7:0];
            3'd6:    byte_sel = chk;
            default: byte_sel = 8'h00;
        endcase
    end

    assign bus.tx_data_o = (state == SEND) ? byte_sel : 8'h00;
    assign bus.tx_en_o   = accept;
    assign bus.ack_o     = ack_q;
    assign bus.busy_o    = busy_q;

endmodule

// File: doc/readout_frame_arbiter.md
# readout_frame_arbiter

Shares the single UART transmit byte port of the readout network between `NumCh` measurement channels, e.g. aging-sensor counters. Selects one requesting channel round-robin, latches its 32-bit word, and pushes a 7-byte framed packet into the UART transmitter's byte FIFO, honouring its full flag. Sits between the sensor readout logic and the UART transmitter: `tx_data_o`/`tx_en_o`/`tx_busy_i` connect to that block's `data_i`/`trans_en_i`/`busy_o`.

## Interface
- `NumCh`, default 4: number of requesting channels; legal range 2..8.
- `clk`  in  1  system clock; same clock as the UART transmitter.
- `rstn`  in  1  reset; asynchronous, active-low.
- `req_i`  in  NumCh  per-channel request, level-sensitive.
- `data_i`  in  NumCh*32  channel c word on bits [32c+31:32c].
- `ack_o`  out  NumCh  one-cycle pulse: the channel's word has been latched.
- `tx_data_o`  out  8  byte to the UART transmitter.
- `tx_en_o`  out  1  write strobe to the UART transmitter; a byte is accepted in every cycle `tx_en_o`=1.
- `tx_busy_i`  in  1  UART transmitter FIFO full.
- `busy_o`  out  1  frame in progress (state SEND).

## Operation
- Frame, 7 bytes, in this order:
  - B0 = 0xA5
  - B1 = {5'b0, id[2:0]}
  - B2..B5 = word[31:24], word[23:16], word[15:8], word[7:0]
  - B6 = B1^B2^B3^B4^B5
- State machine has two states, IDLE and SEND.
- **IDLE:**
  - If any `req_i` bit is set, grant the first requesting channel found searching upward from `last+1` mod NumCh.
  - On the grant edge: latch `data_i` of the granted channel and its id, set `last`=id, clear byte index `idx`=0, move to SEND.
  - If no request is set, stay in IDLE.
- **SEND:**
  - `tx_en_o` = ~`tx_busy_i` (combinational); `tx_data_o` = B[idx].
  - Each accepted byte increments `idx`.
  - Acceptance of B6 (idx=6) returns the machine to IDLE.
- `req_i` is sampled only in IDLE. Requests arriving during SEND are held by the requester and served afterwards.
- After its ack, a requester deasserts `req_i` or presents a new word.
- Changes to `data_i` after the latch edge do not affect the frame in progress.
- **Round-robin fairness:** with all channels requesting continuously, grants cycle 0,1,…,NumCh-1,0,…
- `tx_busy_i` held high stalls SEND indefinitely. There is no timeout and no byte is dropped or duplicated.
- **Reset mid-frame:** the frame is aborted and bytes already accepted stay in the UART FIFO. The host resynchronises on 0xA5 plus checksum.
- **Reset values:**
  - state IDLE, `idx`=0
  - `last`=NumCh-1, so channel 0 has first priority
  - `ack_o`=0, `tx_en_o`=0, `tx_data_o`=0x00, `busy_o`=0
- Outside SEND, `tx_data_o`=0x00 and `tx_en_o`=0.

## Timing
- **Grant:** the grant decision is made in IDLE cycle T. At the edge ending T, state becomes SEND and the word is latched.
- **Ack and busy:** `ack_o[id]` is registered and high for exactly cycle T+1. `busy_o` is high from T+1 until the cycle B6 is accepted, inclusive.
- **First byte:** with `tx_busy_i`=0, B0 is presented and accepted in cycle T+1 and B6 in T+7. The machine is in IDLE at T+8, and the earliest next grant is decided in T+8.
- **Throughput:** minimum frame period is 8 cycles.
- **Stalls:** each cycle with `tx_busy_i`=1 during SEND adds one cycle. `tx_data_o` holds the same byte while stalled.
- **Simultaneous requests:** only one grant per IDLE cycle, and the other requests remain pending.
- **Same-cycle events:** `tx_busy_i` rising in the same cycle suppresses `tx_en_o` in that cycle.

## Test plan
- **Single frame:** NumCh=4, `req_i`=4'b0100, `data_i` ch2=0x12345678, `tx_busy_i`=0 → `ack_o`=4'b0100 for one cycle; bytes A5,02,12,34,56,78,0A on consecutive cycles T+1..T+7; `busy_o` falls after T+7.
- **Round-robin:** `req_i`=4'b1111 held, distinct words per channel → frames in id order 0,1,2,3,0; each ack exactly once per frame; frame starts 8 cycles apart.
- **Backpressure:** ch1 word 0xDEADBEEF, `tx_busy_i` high for 5 cycles after B2 is accepted → `tx_data_o` holds 0xAD with `tx_en_o`=0 throughout the stall; after release, remaining bytes BE,EF then checksum 0x01^DE^AD^BE^EF=0x23; exactly 7 strobes total.
- **Data change after latch:** ch0 word changes from 0x00000001 to 0xFFFFFFFF one cycle after ack → frame carries 00,00,00,01 with checksum 0x01.
- **Reset mid-frame:** assert `rstn`=0 after B3 accepted → all outputs at their reset values immediately; after release with `req_i`=4'b1010, channel 1 is granted first (`last` reset to 3).
- **Late request:** ch3 requests while ch0's frame is in SEND, `tx_busy_i`=0 → ch3 is granted in the first IDLE cycle after B6 of ch0's frame; its ack arrives at T+9, where T is ch0's grant cycle.
